// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/kill controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    localparam int          XLEN_DEF        = 32;
    localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_2000;
    localparam int          CNT_W_DEF       = 32;

    typedef enum logic {
        CTRL_RUN,
        CTRL_TRAP
    } ctrl_state_t;

    typedef struct packed {
        logic fetch;
        logic dec;
        logic exe;
        logic mem;
    } stage_stall_t;

    typedef struct packed {
        logic fetch;
        logic dec;
        logic exe;
        logic mem;
        logic wb;
    } stage_kill_t;

    localparam stage_stall_t STALL_NONE = '{fetch: 1'b0, dec: 1'b0, exe: 1'b0, mem: 1'b0};
    localparam stage_kill_t  KILL_NONE  = '{fetch: 1'b0, dec: 1'b0, exe: 1'b0, mem: 1'b0, wb: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Latency: q reflects inc one clock later.
// Backpressure: none; inc is sampled every cycle.
module pipeline_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/kill arbiter: per-stage stall/kill, PC redirect, 1-cycle trap FSM, perf counters.
// Latency: controls are combinational on inputs+state; epc/FSM/counters update at the next edge.
// Backpressure: dcache_busy freezes the pipe and defers branch/ltu/exception until it drops.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          XLEN        = XLEN_DEF,
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_to_use_hazard,
    input  logic             exe_branch_taken,
    input  logic [XLEN-1:0]  exe_branch_target,
    input  logic             icache_busy,
    input  logic             dcache_busy,
    input  logic             mem_exception,
    input  logic [XLEN-1:0]  mem_exc_pc,
    output logic             stall_fetch,
    output logic             stall_dec,
    output logic             stall_exe,
    output logic             stall_mem,
    output logic             kill_fetch,
    output logic             kill_dec,
    output logic             kill_exe,
    output logic             kill_mem,
    output logic             kill_wb,
    output logic             pc_redirect_valid,
    output logic [XLEN-1:0]  pc_redirect_target,
    output logic [XLEN-1:0]  epc,
    output logic             trap_active,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_ltu_bubbles
);

    ctrl_state_t       state, next_state;
    stage_stall_t      stall;
    stage_kill_t       kill;
    logic              redirect_vld;
    logic [XLEN-1:0]   redirect_dat;
    logic              epc_load;
    logic              ltu_bubble;
    logic [XLEN-1:0]   epc_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  ltu_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CTRL_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (epc_load) begin
            epc_q <= mem_exc_pc;
        end
    end

    // Exactly one priority case drives the controls in a given cycle.
    always_comb begin
        next_state   = state;
        stall        = STALL_NONE;
        kill         = KILL_NONE;
        redirect_vld = 1'b0;
        redirect_dat = '0;
        epc_load     = 1'b0;
        ltu_bubble   = 1'b0;

        if (!rst) begin
            unique case (state)
                CTRL_RUN: begin
                    if (mem_exception && !dcache_busy) begin
                        kill         = '{fetch: 1'b1, dec: 1'b1, exe: 1'b1, mem: 1'b1, wb: 1'b1};
                        redirect_vld = 1'b1;
                        redirect_dat = TRAP_VECTOR[XLEN-1:0];
                        epc_load     = 1'b1;
                        next_state   = CTRL_TRAP;
                    end else if (dcache_busy) begin
                        // Mem stage holds its inst, so wb must see a bubble.
                        stall   = '{fetch: 1'b1, dec: 1'b1, exe: 1'b1, mem: 1'b1};
                        kill.wb = 1'b1;
                    end else if (exe_branch_taken) begin
                        kill.fetch   = 1'b1;
                        kill.dec     = 1'b1;
                        kill.exe     = 1'b1;
                        redirect_vld = 1'b1;
                        redirect_dat = exe_branch_target;
                    end else if (load_to_use_hazard) begin
                        stall.fetch = 1'b1;
                        stall.dec   = 1'b1;
                        kill.exe    = 1'b1;
                        ltu_bubble  = 1'b1;
                    end else if (icache_busy) begin
                        stall.fetch = 1'b1;
                        kill.dec    = 1'b1;
                    end
                end
                CTRL_TRAP: begin
                    // Flush wrong-path insts fetched before the trap redirect landed.
                    kill.fetch = 1'b1;
                    kill.dec   = 1'b1;
                    kill.exe   = 1'b1;
                    next_state = CTRL_RUN;
                end
                default: next_state = CTRL_RUN;
            endcase
        end
    end

    pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall.fetch),
        .q   (stall_cnt)
    );

    pipeline_ctrl_sat_counter #(.W(CNT_W)) u_ltu_cnt (
        .clk (clk),
        .clr (rst),
        .inc (ltu_bubble),
        .q   (ltu_cnt)
    );

    assign stall_fetch        = stall.fetch;
    assign stall_dec          = stall.dec;
    assign stall_exe          = stall.exe;
    assign stall_mem          = stall.mem;
    assign kill_fetch         = kill.fetch;
    assign kill_dec           = kill.dec;
    assign kill_exe           = kill.exe;
    assign kill_mem           = kill.mem;
    assign kill_wb            = kill.wb;
    assign pc_redirect_valid  = redirect_vld;
    assign pc_redirect_target = redirect_dat;

    // Registered outputs are masked so every output reads 0 while rst is held.
    assign epc                = rst ? '0 : epc_q;
    assign trap_active        = !rst && (state == CTRL_TRAP);
    assign perf_stall_cycles  = rst ? '0 : stall_cnt;
    assign perf_ltu_bubbles   = rst ? '0 : ltu_cnt;

endmodule
